regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of writeback requesters (legal range 2..4).
REQ-002 Parameter AW, default 5, SHALL set the register address width.
REQ-003 Parameter DW, default 32, SHALL set the register data width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  SHALL carry per-requester write request valid.
REQ-007 req_ready  out  NUM_REQ  SHALL carry the per-requester grant; one-hot or zero.
REQ-008 req_addr  in  NUM_REQ*AW  SHALL carry packed destination addresses; requester i at bits [i*AW +: AW].
REQ-009 req_data  in  NUM_REQ*DW  SHALL carry packed write data; requester i at bits [i*DW +: DW].
REQ-010 flush  in  1  SHALL cancel the staged write and block grants for that cycle.
REQ-011 rf_we  out  1  SHALL drive the register-file write enable.
REQ-012 rf_waddr  out  AW  SHALL drive the register-file write address.
REQ-013 rf_wdata  out  DW  SHALL drive the register-file write data.

Function
REQ-014 A transfer SHALL occur on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-015 req_ready SHALL be combinational: at most one bit high, and only for a valid requester; all zero when flush=1.
REQ-016 Arbitration SHALL be round-robin: search starts at index rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-017 On a transfer from requester g, rr_ptr SHALL become (g+1) mod NUM_REQ at the next edge; otherwise rr_ptr SHALL hold.
REQ-018 A transfer SHALL load the stage register (valid, addr, data) at the same edge; rf_we/rf_waddr/rf_wdata SHALL be driven from it, giving exactly 1 cycle of latency.
REQ-019 rf_we SHALL be 0 when the staged addr is 0; the request is still granted and consumed, and rr_ptr still advances.
REQ-020 The stage SHALL clear (rf_we=0) at the next edge when no transfer occurs.
REQ-021 flush=1 SHALL clear the stage at the next edge and hold rr_ptr; a requester holding valid SHALL keep its payload stable until granted.
REQ-022 Sustained throughput SHALL be one write per cycle, with no bubble between back-to-back grants.
REQ-023 Requester valid SHALL NOT depend on ready; a deasserted valid SHALL never be granted.

Reset
REQ-024 While rst_n=0, the block SHALL force rr_ptr=0, stage valid=0, stage addr=0 and stage data=0.
REQ-025 In reset, rf_we=0, rf_waddr=0 and rf_wdata=0, taking effect immediately without waiting for a clock edge.
REQ-026 req_ready SHALL be all zero while rst_n=0.
REQ-027 Reset asserted mid-transfer SHALL discard the staged write; no rf_we pulse SHALL follow the deassertion.

Configuration
REQ-028 Macro RFARB_FWD_EN, when defined, SHALL add the following ports.
- Inputs: rs1_addr, rs2_addr (AW); rf_rs1_data, rf_rs2_data (DW).
- Outputs: rs1_data, rs2_data (DW).
REQ-029 With RFARB_FWD_EN, rsN_data SHALL equal the stage data when rf_we=1 and rsN_addr equals rf_waddr; otherwise it SHALL equal rf_rsN_data.
REQ-030 With RFARB_FWD_EN, the forwarding path SHALL be combinational, and address 0 SHALL never forward.
REQ-031 Without RFARB_FWD_EN, the forwarding ports and logic SHALL be absent; the block SHALL otherwise behave identically.

Structure
REQ-032 Package regfile_pkg SHALL hold the constants REG_AW=5, REG_DW=32 and REG_ZERO=0, plus the typedef rf_wr_t {we, addr, data}.
REQ-033 The round-robin grant SHALL be a sub-module rr_arbiter with inputs (req, ptr) and output one-hot grant, purely combinational.
REQ-034 The stage register, rr_ptr register and forwarding mux SHALL reside in regfile_wb_arbiter.

Verification
REQ-035 Reset check: hold rst_n=0 with all valids high -> req_ready=000 and rf_we=0; release rst_n -> first grant is req 0.
REQ-036 Rotation check: all three valids held high for 6 cycles -> grants 0,1,2,0,1,2 and an rf_we pulse every cycle after the first.
REQ-037 Sequential write check: req1 writes addr 7 data 0xDEADBEEF in cycle N -> rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF in cycle N+1; rf_we=0 in cycle N+2.
REQ-038 Zero-address check: req0 writes addr 0 data 0x1234 -> req_ready[0]=1 and rf_we stays 0; the next grant goes to req1 when valid.
REQ-039 Flush check: flush=1 in the cycle after the req2 grant -> rf_we=0 in the following cycle; req_ready=000 during flush; rr_ptr unchanged.
REQ-040 Forwarding check (RFARB_FWD_EN): staged write addr 5 data 0xA5A5A5A5 with rs1_addr=5 and rf_rs1_data=0 -> rs1_data=0xA5A5A5A5; with rs2_addr=0 -> rs2_data=rf_rs2_data.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the writeback record type for the register-file writeback arbiter.
package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request at or after ptr.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        // Visit positions ptr, ptr+1, ... wrapping; the first requester seen wins.
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + k) % N))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding a one-cycle stage that drives the register-file write port.
// Optional macro RFARB_FWD_EN adds combinational read-port forwarding from the staged write.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = REG_AW,
    parameter int DW      = REG_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic                  flush,
`ifdef RFARB_FWD_EN
    input  logic [AW-1:0]         rs1_addr,
    input  logic [AW-1:0]         rs2_addr,
    input  logic [DW-1:0]         rf_rs1_data,
    input  logic [DW-1:0]         rf_rs2_data,
    output logic [DW-1:0]         rs1_data,
    output logic [DW-1:0]         rs2_data,
`endif
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               stage_we_q, stage_we_d;
    logic [AW-1:0]      stage_addr_q, stage_addr_d;
    logic [DW-1:0]      stage_data_q, stage_data_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic               xfer;
    logic [PW-1:0]      g_idx;
    logic [AW-1:0]      g_addr;
    logic [DW-1:0]      g_data;

    // Reset and flush both suppress every grant combinationally.
    assign arb_req = req_valid & {NUM_REQ{rst_n & ~flush}};

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        xfer         = |gnt;
        g_idx        = '0;
        g_addr       = '0;
        g_data       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                g_idx  = PW'(i);
                g_addr = req_addr[i*AW +: AW];
                g_data = req_data[i*DW +: DW];
            end
        end

        rr_ptr_d     = rr_ptr_q;
        stage_we_d   = 1'b0;
        stage_addr_d = '0;
        stage_data_d = '0;
        if (xfer) begin
            rr_ptr_d     = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
            // Writes to register zero are consumed but never reach the register file.
            stage_we_d   = (g_addr != AW'(REG_ZERO));
            stage_addr_d = g_addr;
            stage_data_d = g_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            stage_we_q   <= 1'b0;
            stage_addr_q <= '0;
            stage_data_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            stage_we_q   <= stage_we_d;
            stage_addr_q <= stage_addr_d;
            stage_data_q <= stage_data_d;
        end
    end

    assign rf_we    = stage_we_q;
    assign rf_waddr = stage_addr_q;
    assign rf_wdata = stage_data_q;

`ifdef RFARB_FWD_EN
    assign rs1_data = (stage_we_q && (rs1_addr == stage_addr_q) && (rs1_addr != AW'(REG_ZERO)))
                      ? stage_data_q : rf_rs1_data;
    assign rs2_data = (stage_we_q && (rs2_addr == stage_addr_q) && (rs2_addr != AW'(REG_ZERO)))
                      ? stage_data_q : rf_rs2_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              flush;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
`ifdef RFARB_FWD_EN
    logic [AW-1:0]     rs1_addr = '0;
    logic [AW-1:0]     rs2_addr = '0;
    logic [DW-1:0]     rf_rs1_data = '0;
    logic [DW-1:0]     rf_rs2_data = '0;
    logic [DW-1:0]     rs1_data;
    logic [DW-1:0]     rs2_data;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int                m_ptr = 0;
    logic              m_we = 1'b0;
    logic [AW-1:0]     m_addr = '0;
    logic [DW-1:0]     m_data = '0;
    int                last_gnt = -1;
    logic [AW+DW-1:0]  exp_q[$];

    regfile_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .flush       (flush),
`ifdef RFARB_FWD_EN
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
`endif
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Compare process: sampled mid-cycle, inputs are stable from 1 unit after posedge.
    always @(negedge clk) begin : cmp
        int g;
        int idx;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW+DW-1:0] e;
        if (!rst_n) begin
            check("rst_ready", 64'(req_ready), 64'(0));
            check("rst_we", 64'(rf_we), 64'(0));
            check("rst_waddr", 64'(rf_waddr), 64'(0));
            check("rst_wdata", 64'(rf_wdata), 64'(0));
            m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
            exp_q.delete();
            last_gnt = -1;
        end else begin
            g = -1;
            if (!flush) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            check("model_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
            check("model_we", 64'(rf_we), 64'(m_we));
            if (m_we) begin
                check("model_waddr", 64'(rf_waddr), 64'(m_addr));
                check("model_wdata", 64'(rf_wdata), 64'(m_data));
            end
`ifdef RFARB_FWD_EN
            check("model_rs1", 64'(rs1_data), (m_we && rs1_addr == m_addr) ? 64'(m_data) : 64'(rf_rs1_data));
            check("model_rs2", 64'(rs2_data), (m_we && rs2_addr == m_addr) ? 64'(m_data) : 64'(rf_rs2_data));
`endif
            // scoreboard: every nonzero-address grant must surface once, in order
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_write", 64'({rf_waddr, rf_wdata}), 64'(e));
                end
            end
            if (g >= 0) begin
                a = req_addr[g*AW +: AW];
                d = req_data[g*DW +: DW];
                m_we = (a != 0); m_addr = a; m_data = d;
                m_ptr = (g + 1) % N;
                if (a != 0) exp_q.push_back({a, d});
            end else begin
                m_we = 1'b0; m_addr = '0; m_data = '0;
            end
            last_gnt = g;
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        req_valid = '0; req_addr = '0; req_data = '0; flush = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));

        // reset held with all valids high
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'(0));
        check("reset_we", 64'(rf_we), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // rotation: grants 0,1,2,0,1,2; writes every cycle after the first
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rot_ready", 64'(req_ready), 64'(1) << (k % 3));
            check("rot_we", 64'(rf_we), (k > 0) ? 64'(1) : 64'(0));
            next_cycle();
        end

        // sequential write from requester 1
        req_valid = '0;
        set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
        @(negedge clk);
        check("seq_ready", 64'(req_ready), 64'(3'b010));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("seq_we", 64'(rf_we), 64'(1));
        check("seq_waddr", 64'(rf_waddr), 64'(7));
        check("seq_wdata", 64'(rf_wdata), 64'(32'hDEADBEEF));
        next_cycle();
        @(negedge clk);
        check("seq_we_off", 64'(rf_we), 64'(0));

        // zero address: pointer sits at 2, req0 and req1 valid
        next_cycle();
        set_req(0, 1'b1, 5'd0, 32'h1234);
        set_req(1, 1'b1, 5'd3, 32'h55AA);
        @(negedge clk);
        check("zero_ready", 64'(req_ready), 64'(3'b001));
        next_cycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("zero_next_ready", 64'(req_ready), 64'(3'b010));
        check("zero_we", 64'(rf_we), 64'(0));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("zero_after_we", 64'(rf_we), 64'(1));
        check("zero_after_waddr", 64'(rf_waddr), 64'(3));

        // flush the cycle after a req2 grant
        next_cycle();
        set_req(2, 1'b1, 5'd9, 32'hCAFE);
        @(negedge clk);
        check("flush_pre_ready", 64'(req_ready), 64'(3'b100));
        next_cycle();
        flush = 1'b1;
        set_req(0, 1'b1, 5'd11, 32'h0B0B);
        set_req(1, 1'b1, 5'd12, 32'h0C0C);
        set_req(2, 1'b1, 5'd13, 32'h0D0D);
        @(negedge clk);
        check("flush_ready", 64'(req_ready), 64'(0));
        check("flush_we_still", 64'(rf_we), 64'(1));
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush_we_after", 64'(rf_we), 64'(0));
        check("flush_ptr_held", 64'(req_ready), 64'(3'b001));

        // reset mid-transfer: staged write must vanish immediately and not reappear
        next_cycle();
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_we", 64'(rf_we), 64'(0));
        check("midrst_waddr", 64'(rf_waddr), 64'(0));
        check("midrst_wdata", 64'(rf_wdata), 64'(0));
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_pulse", 64'(rf_we), 64'(0));
        end

`ifdef RFARB_FWD_EN
        next_cycle();
        set_req(0, 1'b1, 5'd5, 32'hA5A5A5A5);
        next_cycle();
        req_valid = '0;
        rs1_addr = 5'd5; rf_rs1_data = '0;
        rs2_addr = 5'd0; rf_rs2_data = 32'h13579BDF;
        @(negedge clk);
        check("fwd_rs1", 64'(rs1_data), 64'(32'hA5A5A5A5));
        check("fwd_rs2", 64'(rs2_data), 64'(32'h13579BDF));
`endif

        // randomized traffic: valid held with stable payload until granted
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (last_gnt == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'b1,
                            ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
                            DW'($urandom));
            end
            flush = ($urandom_range(0, 9) == 0);
`ifdef RFARB_FWD_EN
            rs1_addr = AW'($urandom_range(0, 31)); rf_rs1_data = DW'($urandom);
            rs2_addr = (rs1_addr == 0) ? rf_waddr : AW'($urandom_range(0, 31));
            rf_rs2_data = DW'($urandom);
`endif
        end
        next_cycle();
        req_valid = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
